// File: rtl/rr_grant_pkg.sv
// Shared types and widths for the four-way round-robin grant sequencer.
package rr_grant_pkg;
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int HOLD_W  = 8;
   localparam int GAP_W   = 3;
endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority search over four requests, starting at ptr and wrapping.
module rr_pick4
   import rr_grant_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic               found,
   output logic [SEL_W-1:0]   idx
);
   logic [SEL_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end
endmodule

// File: rtl/rr_grant_seq.sv
// Round-robin grant FSM feeding a 2-to-4 active-low decoder (sel -> A/B, en -> EN).
module rr_grant_seq
   import rr_grant_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int MAX_HOLD   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [SEL_W-1:0]   sel,
   output logic               en,
   output logic               timeout
);
   localparam bit               TO_EN     = (MAX_HOLD != 0);
   localparam bit               GAP_EN    = (GAP_CYCLES > 0);
   localparam logic [HOLD_W-1:0] HOLD_LAST = TO_EN  ? HOLD_W'(MAX_HOLD - 1)  : '0;
   localparam logic [GAP_W-1:0]  GAP_LD    = GAP_EN ? GAP_W'(GAP_CYCLES - 1) : '0;

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, ptr_rel;
   logic              en_q, en_d, to_q, to_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              idle_found, b2b_found, rel_norm, rel_to;
   logic [SEL_W-1:0]  idle_idx, b2b_idx;

   assign ptr_rel = sel_q + SEL_W'(1);

   rr_pick4 u_pick_idle (.req(req), .ptr(ptr_q),   .found(idle_found), .idx(idle_idx));
   rr_pick4 u_pick_b2b  (.req(req), .ptr(ptr_rel), .found(b2b_found),  .idx(b2b_idx));

   assign rel_norm = done | ~req[sel_q];
   assign rel_to   = TO_EN && (hold_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      en_d    = en_q;
      to_d    = 1'b0;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      case (state_q)
         IDLE: begin
            en_d = 1'b0;
            if (idle_found) begin
               sel_d   = idle_idx;
               en_d    = 1'b1;
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (rel_norm || rel_to) begin
               // A normal release in the timeout cycle suppresses the pulse.
               to_d  = ~rel_norm;
               ptr_d = ptr_rel;
               if (GAP_EN) begin
                  en_d    = 1'b0;
                  gap_d   = GAP_LD;
                  state_d = GAP;
               end else if (b2b_found) begin
                  sel_d  = b2b_idx;
                  en_d   = 1'b1;
                  hold_d = '0;
               end else begin
                  en_d    = 1'b0;
                  state_d = IDLE;
               end
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         GAP: begin
            en_d = 1'b0;
            if (gap_q == '0) state_d = IDLE;
            else             gap_d   = gap_q - GAP_W'(1);
         end
         default: begin
            en_d    = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         en_q    <= 1'b0;
         to_q    <= 1'b0;
         ptr_q   <= '0;
         hold_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         to_q    <= to_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
      end
   end

   assign sel     = sel_q;
   assign en      = en_q;
   assign timeout = to_q;
endmodule

// File: tb/tb_rr_grant_seq.sv
// Three parameterisations of rr_grant_seq checked against an abstract grant model.
module tb_rr_grant_seq;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_a [3];
   logic       done_a [3];
   logic [1:0] sel_o [3];
   logic       en_o [3];
   logic       to_o [3];

   int gapp [3] = '{1, 1, 0};
   int maxh [3] = '{16, 4, 5};

   // Model: owner index, grant length so far, dead cycles left, rotation start.
   int m_ptr [3], m_sel [3], m_held [3], m_gap [3];
   bit m_en [3], m_to [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rr_grant_seq #(.GAP_CYCLES(1), .MAX_HOLD(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req_a[0]), .done(done_a[0]),
      .sel(sel_o[0]), .en(en_o[0]), .timeout(to_o[0]));
   rr_grant_seq #(.GAP_CYCLES(1), .MAX_HOLD(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req_a[1]), .done(done_a[1]),
      .sel(sel_o[1]), .en(en_o[1]), .timeout(to_o[1]));
   rr_grant_seq #(.GAP_CYCLES(0), .MAX_HOLD(5)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req_a[2]), .done(done_a[2]),
      .sel(sel_o[2]), .en(en_o[2]), .timeout(to_o[2]));

   function automatic int pick(logic [3:0] r, int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic chk(string tag, int obs, int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int w;
      bit normal, tmo;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_ptr[i] = 0; m_sel[i] = 0; m_en[i] = 0; m_to[i] = 0;
            m_held[i] = 0; m_gap[i] = 0;
         end else begin
            m_to[i] = 0;
            if (m_en[i]) begin
               m_held[i]++;
               normal = done_a[i] || !req_a[i][m_sel[i]];
               tmo    = (maxh[i] > 0) && (m_held[i] == maxh[i]);
               if (normal || tmo) begin
                  m_to[i]  = !normal;
                  m_ptr[i] = (m_sel[i] + 1) % 4;
                  if (gapp[i] > 0) begin
                     m_en[i]  = 0;
                     m_gap[i] = gapp[i];
                  end else begin
                     w = pick(req_a[i], m_ptr[i]);
                     if (w >= 0) begin m_sel[i] = w; m_held[i] = 0; end
                     else m_en[i] = 0;
                  end
               end
            end else if (m_gap[i] > 0) begin
               m_gap[i]--;
            end else begin
               w = pick(req_a[i], m_ptr[i]);
               if (w >= 0) begin m_sel[i] = w; m_en[i] = 1; m_held[i] = 0; end
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("model_sel[%0d]", i), int'(sel_o[i]), m_sel[i]);
         chk($sformatf("model_en[%0d]", i),  int'(en_o[i]),  int'(m_en[i]));
         chk($sformatf("model_to[%0d]", i),  int'(to_o[i]),  int'(m_to[i]));
      end
   endtask

   task automatic drive(logic [3:0] r, logic d);
      for (int i = 0; i < 3; i++) begin req_a[i] = r; done_a[i] = d; end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      drive(4'b0000, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      chk("reset_en", int'(en_o[0]), 0);
      chk("reset_sel", int'(sel_o[0]), 0);
      chk("reset_to", int'(to_o[0]), 0);
      rst_n = 1'b1;

      // Single grant, then pointer moves past the owner.
      drive(4'b0100, 1'b0); tick();
      chk("single_en", int'(en_o[0]), 1);
      chk("single_sel", int'(sel_o[0]), 2);
      drive(4'b0100, 1'b1); tick();
      chk("single_release", int'(en_o[0]), 0);
      drive(4'b1111, 1'b0); tick(); tick();
      chk("ptr_after_release", int'(sel_o[0]), 3);

      // Rotation with done every third cycle.
      do_reset();
      for (int c = 0; c < 30; c++) begin
         drive(4'b1111, (c % 3) == 2);
         tick();
      end

      // Timeout on MAX_HOLD=4, then requester 1 is next.
      drive(4'b0000, 1'b0); do_reset();
      drive(4'b0011, 1'b0); tick();
      chk("to_grant_sel", int'(sel_o[1]), 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("to_still_en", int'(en_o[1]), 1);
      end
      tick();
      chk("to_en_drop", int'(en_o[1]), 0);
      chk("to_pulse", int'(to_o[1]), 1);
      tick();
      chk("to_pulse_end", int'(to_o[1]), 0);
      tick();
      chk("to_next_en", int'(en_o[1]), 1);
      chk("to_next_sel", int'(sel_o[1]), 1);

      // done coinciding with the timeout cycle is a normal release.
      drive(4'b0000, 1'b0); do_reset();
      drive(4'b0001, 1'b0); tick(); tick(); tick(); tick();
      drive(4'b0001, 1'b1); tick();
      chk("simul_en", int'(en_o[1]), 0);
      chk("simul_to", int'(to_o[1]), 0);

      // Withdrawal mid-grant.
      drive(4'b0000, 1'b0); do_reset();
      drive(4'b0001, 1'b0); tick(); tick();
      drive(4'b0000, 1'b0); tick();
      chk("withdraw_en", int'(en_o[0]), 0);

      // Back-to-back handover with GAP_CYCLES=0.
      do_reset();
      drive(4'b1010, 1'b0); tick();
      chk("b2b_first_sel", int'(sel_o[2]), 1);
      drive(4'b1010, 1'b1); tick();
      chk("b2b_en_kept", int'(en_o[2]), 1);
      chk("b2b_second_sel", int'(sel_o[2]), 3);

      // Reset while granted to requester 3.
      drive(4'b0000, 1'b0); do_reset();
      drive(4'b1000, 1'b0); tick();
      chk("rstmid_pre_sel", int'(sel_o[0]), 3);
      rst_n = 1'b0; tick();
      chk("rstmid_en", int'(en_o[0]), 0);
      chk("rstmid_sel", int'(sel_o[0]), 0);
      chk("rstmid_to", int'(to_o[0]), 0);
      rst_n = 1'b1; tick();
      chk("rstmid_regrant", int'(sel_o[0]), 3);

      // Randomized level requests, sporadic done and rare resets.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 5) == 0) req_a[i] = 4'($urandom_range(0, 15));
            done_a[i] = ($urandom_range(0, 4) == 0);
         end
         rst_n = ($urandom_range(0, 80) != 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
